// File: rtl/e_tuple_delay_pkg.sv
// Shared defaults and helpers for the parametrised tuple delay line.
// Holds default field widths and depth, the occupancy-counter width helper,
// and the stage record layout {valid, data} for the default tuple width.
package e_tuple_delay_pkg;

  localparam int DEF_A_W   = 4;
  localparam int DEF_B_W   = 4;
  localparam int DEF_DEPTH = 3;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One stage of the line at default widths: valid bit above the packed tuple.
  typedef struct packed {
    logic                       valid;
    logic [DEF_A_W+DEF_B_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/e_delay_stage.sv
// One delay stage: registered data word plus valid bit.
// Latency: 1 cycle. Backpressure: stall_i freezes data and valid; flush_i
// clears valid (even while stalled) and leaves data on its normal path.
// Ports: clk_i/rst_n_i (async active-low), stall_i, flush_i, data_i/valid_i in,
//        data_o/valid_o registered out.
module e_delay_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  // Same {valid, data} layout as the package stage_t, sized for this instance.
  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
  } rec_t;

  rec_t rec_q, rec_d;

  always_comb begin
    rec_d = rec_q;
    if (!stall_i) begin
      rec_d.data  = data_i;
      rec_d.valid = valid_i;
    end
    // Flush overrides stall for the valid bit only; data keeps its hold/load.
    if (flush_i) begin
      rec_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign data_o  = rec_q.data;
  assign valid_o = rec_q.valid;

endmodule

// File: rtl/e_tuple_delay_n.sv
// DEPTH-stage delay line for a 2-tuple {input1_i, input2_i} with output valid.
// Latency: DEPTH unstalled edges. Backpressure: stall_i freezes all stages,
// flush_i drops every in-flight valid (including the tuple being captured).
// Ports: clk_i, rst_n_i (async active-low), input1_i/input2_i/in_valid_i,
//        stall_i, flush_i, output__ (unmasked data), out_valid_o,
//        occ_o (valid-stage count, only when E_TUPLE_DELAY_OCC_EN is defined).
module e_tuple_delay_n
  import e_tuple_delay_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [A_W-1:0]     input1_i,
  input  logic [B_W-1:0]     input2_i,
  input  logic               in_valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [A_W+B_W-1:0] output__,
  output logic               out_valid_o
`ifdef E_TUPLE_DELAY_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ_o
`endif
);

  localparam int W = A_W + B_W;

  if (DEPTH < 1) begin : g_bad_depth
    $error("e_tuple_delay_n: DEPTH must be at least 1");
  end

  // Element k feeds stage k; element DEPTH is the last stage's output.
  logic [W-1:0] dat_chain [DEPTH+1];
  logic         vld_chain [DEPTH+1];

  assign dat_chain[0] = {input1_i, input2_i};
  assign vld_chain[0] = in_valid_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    e_delay_stage #(
      .W(W)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .data_i  (dat_chain[k]),
      .valid_i (vld_chain[k]),
      .data_o  (dat_chain[k+1]),
      .valid_o (vld_chain[k+1])
    );
  end

  assign output__    = dat_chain[DEPTH];
  assign out_valid_o = vld_chain[DEPTH];

`ifdef E_TUPLE_DELAY_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_q, occ_d;

  // Tracks the popcount of stage valids incrementally: one enters at stage 0,
  // one leaves from the last stage, flush empties everything.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (!stall_i) begin
      occ_d = occ_q + OW'(in_valid_i) - OW'(out_valid_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;
`endif

endmodule

// File: tb/tb_e_tuple_delay_n.sv
module tb_e_tuple_delay_n;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [3:0] in1, in2;
  logic       vin, stall, flush;

  logic [7:0] out3, out4, out5;
  logic       vld3, vld4, vld5;
  logic [1:0] occ3;
  logic [2:0] occ4, occ5;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk_i = ~clk_i;

  e_tuple_delay_n #(.A_W(4), .B_W(4), .DEPTH(3)) u_dut3 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .input1_i(in1), .input2_i(in2),
    .in_valid_i(vin), .stall_i(stall), .flush_i(flush),
    .output__(out3), .out_valid_o(vld3)
`ifdef E_TUPLE_DELAY_OCC_EN
    , .occ_o(occ3)
`endif
  );

  e_tuple_delay_n #(.A_W(4), .B_W(4), .DEPTH(4)) u_dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .input1_i(in1), .input2_i(in2),
    .in_valid_i(vin), .stall_i(stall), .flush_i(flush),
    .output__(out4), .out_valid_o(vld4)
`ifdef E_TUPLE_DELAY_OCC_EN
    , .occ_o(occ4)
`endif
  );

  e_tuple_delay_n #(.A_W(4), .B_W(4), .DEPTH(5)) u_dut5 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .input1_i(in1), .input2_i(in2),
    .in_valid_i(vin), .stall_i(stall), .flush_i(flush),
    .output__(out5), .out_valid_o(vld5)
`ifdef E_TUPLE_DELAY_OCC_EN
    , .occ_o(occ5)
`endif
  );

`ifndef E_TUPLE_DELAY_OCC_EN
  assign occ3 = '0;
  assign occ4 = '0;
  assign occ5 = '0;
`endif

  // Model: history of tuples accepted on unstalled edges, newest first.
  // A DEPTH-d line shows the entry accepted d effective edges ago.
  typedef struct {
    logic [7:0] d;
    bit         v;
  } ent_t;
  ent_t hist[$];

  always @(negedge rst_n_i) hist.delete();

  always @(posedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      if (flush) begin
        foreach (hist[i]) hist[i].v = 1'b0;
      end
      if (!stall) begin
        hist.push_front('{d: {in1, in2}, v: (vin && !flush)});
        if (hist.size() > 8) void'(hist.pop_back());
      end
    end
  end

  function automatic logic [8:0] model_out(input int depth);
    if (hist.size() >= depth) return {hist[depth-1].v, hist[depth-1].d};
    return 9'h000;
  endfunction

  function automatic int model_occ(input int depth);
    int n = 0;
    for (int i = 0; i < depth && i < hist.size(); i++) if (hist[i].v) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk_i) begin
    logic [8:0] e3, e4, e5;
    e3 = model_out(3);
    e4 = model_out(4);
    e5 = model_out(5);
    chk("cmp_d3", {23'd0, vld3, out3}, {23'd0, e3});
    chk("cmp_d4", {23'd0, vld4, out4}, {23'd0, e4});
    chk("cmp_d5", {23'd0, vld5, out5}, {23'd0, e5});
`ifdef E_TUPLE_DELAY_OCC_EN
    chk("cmp_occ3", 32'(occ3), 32'(model_occ(3)));
    chk("cmp_occ4", 32'(occ4), 32'(model_occ(4)));
    chk("cmp_occ5", 32'(occ5), 32'(model_occ(5)));
`endif
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic f);
    {in1, in2} = d;
    vin   = v;
    stall = s;
    flush = f;
  endtask

  initial begin
    logic [7:0] prev;
    int occ_exp[9];
    occ_exp = '{1, 1, 2, 3, 3, 3, 2, 1, 0};

    rst_n_i = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_out3", {24'd0, out3}, 32'h0);
    chk("reset_vld3", {31'd0, vld3}, 32'h0);
    rst_n_i = 1'b1;

    // Legacy behaviour on the 3-deep line: a single 1 pulse, 3 edges of latency.
    drive(8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("legacy_out_1", {24'd0, out3}, 32'h01);
    chk("legacy_vld_1", {31'd0, vld3}, 32'h1);
    tick();
    chk("legacy_out_0", {24'd0, out3}, 32'h00);

    // Clean out, then a stalled A5 arrives 2 edges late.
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall_not_yet", {31'd0, vld3}, 32'h0);
    tick();
    chk("stall_out", {24'd0, out3}, 32'hA5);
    chk("stall_vld", {31'd0, vld3}, 32'h1);

    // Three valid tuples in flight, then flush with a valid input (dropped).
    drive(8'h11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h22, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_flush_vld", {31'd0, vld3}, 32'h1);
    chk("pre_flush_out", {24'd0, out3}, 32'h11);
    drive(8'h44, 1'b1, 1'b0, 1'b1);
    tick();
`ifdef E_TUPLE_DELAY_OCC_EN
    chk("flush_occ3", 32'(occ3), 32'h0);
    chk("flush_occ5", 32'(occ5), 32'h0);
`endif
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("post_flush_vld", {31'd0, vld3}, 32'h0);
      tick();
    end

    // Flush and stall together with two in flight: valids cleared, data held.
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h66, 1'b1, 1'b0, 1'b0);
    tick();
    prev = out3;
    drive(8'h77, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fs_out_hold", {24'd0, out3}, {24'd0, prev});
    chk("fs_vld3", {31'd0, vld3}, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fs_after_vld3", {31'd0, vld3}, 32'h0);
    end

    // Fill the 5-deep line, then an async reset pulse between edges.
    for (int i = 0; i < 5; i++) begin
      drive(8'h71 + 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("full5_vld", {31'd0, vld5}, 32'h1);
    chk("full5_out", {24'd0, out5}, 32'h71);
    #1 rst_n_i = 1'b0;
    #1;
    chk("arst_out5", {24'd0, out5}, 32'h0);
    chk("arst_vld5", {31'd0, vld5}, 32'h0);
    chk("arst_out3", {24'd0, out3}, 32'h0);
    #1 rst_n_i = 1'b1;

    // Valid pattern 1,0,1,1,1 then idle on the 4-deep line.
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 2, 3, 4: drive(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
        default:    drive(8'h00, 1'b0, 1'b0, 1'b0);
      endcase
      tick();
      if (i == 3) chk("occ_seq_vld4", {31'd0, vld4}, 32'h1);
`ifdef E_TUPLE_DELAY_OCC_EN
      chk("occ_seq", 32'(occ4), 32'(occ_exp[i]));
`endif
    end

    // Randomised traffic checked by the comparison process.
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
      tick();
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
